// File: rtl/alu_muldiv_seq.sv
// Sequential 16-bit unsigned multiply / restoring divide that borrows the shared
// execute-stage ALU for every add/subtract, one iteration per clock.
module alu_muldiv_seq #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             dz,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [2:0]       alu_cmd,
  input  logic [WIDTH-1:0] alu_res
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
  localparam logic [2:0] CMD_ADD = 3'b000;
  localparam logic [2:0] CMD_SUB = 3'b001;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             opSel_q, opSel_d;
  // acc doubles as the divide remainder; opA is mc/quotient, opB is mp/divisor
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] resLo_q, resLo_d;
  logic [WIDTH-1:0] resHi_q, resHi_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] shiftedRem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opSel_q <= 1'b0;
      acc_q   <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
      resLo_q <= '0;
      resHi_q <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opSel_q <= opSel_d;
      acc_q   <= acc_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      resLo_q <= resLo_d;
      resHi_q <= resHi_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opSel_d    = opSel_q;
    acc_d      = acc_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    resLo_d    = resLo_q;
    resHi_d    = resHi_q;
    dz_d       = dz_q;
    alu_op1    = '0;
    alu_op2    = '0;
    alu_cmd    = CMD_ADD;
    shiftedRem = {acc_q[WIDTH-2:0], opA_q[WIDTH-1]};

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opSel_d = op;
          if (op && (b == '0)) begin
            state_d = DONE;
            resLo_d = '1;
            resHi_d = a;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            dz_d    = 1'b0;
            acc_d   = '0;
            opA_d   = a;
            opB_d   = b;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!opSel_q) begin
          alu_op1 = acc_q;
          alu_op2 = opA_q;
          alu_cmd = CMD_ADD;
          if (opB_q[0]) acc_d = alu_res;
          opA_d = opA_q << 1;
          opB_d = opB_q >> 1;
        end else begin
          alu_op1 = shiftedRem;
          alu_op2 = opB_q;
          alu_cmd = CMD_SUB;
          if (shiftedRem >= opB_q) begin
            acc_d = alu_res;
            opA_d = {opA_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = shiftedRem;
            opA_d = {opA_q[WIDTH-2:0], 1'b0};
          end
        end
        // Results capture the values produced by this final iteration
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          resLo_d = opSel_q ? opA_d : acc_d;
          resHi_d = opSel_q ? acc_d : '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign res_lo = resLo_q;
  assign res_hi = resHi_q;
  assign dz     = dz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: stimulus pushes expected results, a
// monitor pops and compares on every done pulse. Includes a behavioural ALU.
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] res_lo;
  logic [15:0] res_hi;
  logic        dz;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [2:0]  alu_cmd;
  logic [15:0] alu_res;

  typedef struct {
    string       name;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycleCount = 0;

  alu_muldiv_seq #(.WIDTH(16), .ITER(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .res_lo(res_lo), .res_hi(res_hi), .dz(dz),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cmd(alu_cmd), .alu_res(alu_res)
  );

  // Stand-in for the shared execute-stage ALU
  assign alu_res = (alu_cmd == 3'b001) ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Caller is at a negedge; start is held for one edge, so returns at the negedge after acceptance
  task automatic applyStimulus(input string name, input logic opIn, input logic [15:0] aIn,
                               input logic [15:0] bIn, input logic [15:0] expLo,
                               input logic [15:0] expHi, input logic expDz, input bit push);
    exp_t e;
    start = 1'b1;
    op    = opIn;
    a     = aIn;
    b     = bIn;
    if (push) begin
      e.name = name;
      e.lo   = expLo;
      e.hi   = expHi;
      e.dz   = expDz;
      e.cyc  = cycleCount + 1 + (expDz ? 0 : 16);
      sbQ.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: done timeout, got none expected pulse", name);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && done) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spuriousDone: got done=1 expected no pending operation");
      end else begin
        e = sbQ.pop_front();
        checkOutput({e.name, ".res_lo"}, 32'(res_lo), 32'(e.lo));
        checkOutput({e.name, ".res_hi"}, 32'(res_hi), 32'(e.hi));
        checkOutput({e.name, ".dz"}, 32'(dz), 32'(e.dz));
        checkOutput({e.name, ".doneCycle"}, 32'(cycleCount), 32'(e.cyc));
        checkOutput({e.name, ".busyWithDone"}, 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.res_lo", 32'(res_lo), 32'd0);
    checkOutput("reset.res_hi", 32'(res_hi), 32'd0);
    checkOutput("reset.dz", 32'(dz), 32'd0);
    checkOutput("reset.alu", {13'd0, alu_cmd, alu_op1 | alu_op2}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("mul7x9", 1'b0, 16'd7, 16'd9, 16'd63, 16'd0, 1'b0, 1);
    checkOutput("mul7x9.busyInRun", 32'(busy), 32'd1);
    checkOutput("mul7x9.aluCmd", 32'(alu_cmd), 32'd0);
    waitDone("mul7x9");
    @(negedge clk);

    applyStimulus("mulWrap", 1'b0, 16'h1234, 16'h0110, 16'h5740, 16'd0, 1'b0, 1);
    waitDone("mulWrap");
    @(negedge clk);

    applyStimulus("div100by7", 1'b1, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1);
    checkOutput("div100by7.aluCmd", 32'(alu_cmd), 32'd1);
    waitDone("div100by7");
    @(negedge clk);

    applyStimulus("divFFFFby1", 1'b1, 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 1);
    waitDone("divFFFFby1");
    @(negedge clk);

    applyStimulus("divBy0", 1'b1, 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1);
    checkOutput("divBy0.busy", 32'(busy), 32'd0);
    waitDone("divBy0");
    @(negedge clk);
    checkOutput("divBy0.busyAfter", 32'(busy), 32'd0);
    checkOutput("holdIdle.res_hi", 32'(res_hi), 32'd5);

    // start stays high with new operands for several RUN cycles
    applyStimulus("heldStart", 1'b0, 16'd11, 16'd13, 16'd143, 16'd0, 1'b0, 1);
    start = 1'b1;
    op    = 1'b1;
    a     = 16'd2;
    b     = 16'd2;
    repeat (6) @(negedge clk);
    start = 1'b0;
    waitDone("heldStart");
    @(negedge clk);

    applyStimulus("div1000by10", 1'b1, 16'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 1);
    waitDone("div1000by10");
    applyStimulus("backToBack6x7", 1'b0, 16'd6, 16'd7, 16'd42, 16'd0, 1'b0, 1);
    waitDone("backToBack6x7");
    @(negedge clk);

    applyStimulus("aborted", 1'b0, 16'h1234, 16'h0110, 16'd0, 16'd0, 1'b0, 0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midReset.busy", 32'(busy), 32'd0);
    checkOutput("midReset.done", 32'(done), 32'd0);
    checkOutput("midReset.res_lo", 32'(res_lo), 32'd0);
    checkOutput("midReset.res_hi", 32'(res_hi), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    applyStimulus("mul3x4", 1'b0, 16'd3, 16'd4, 16'd12, 16'd0, 1'b0, 1);
    waitDone("mul3x4");
    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
